// File: rtl/debug_pkg.sv
// Shared constants for the debug UART link: command bytes,
// status characters and the receive FSM state encoding.
package debug_pkg;

  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam logic [7:0] STATUS_HALT = 8'h48;
  localparam logic [7:0] STATUS_RUN  = 8'h43;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, bit FSM, byte and
// frame-error strobes. Companion of uart_tx.
module uart_rx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_W =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_W =
    CW'(CLKS_PER_BIT - 1);

  rx_state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic bv_q, bv_d;
  logic fe_q, fe_d;
  logic armed_q, armed_d;
  logic rxs;

  assign rxs         = sync_q[SYNC_STAGES-1];
  assign rx_byte     = byte_q;
  assign byte_valid  = bv_q;
  assign frame_error = fe_q;

  // armed_q blocks a line held low across reset from
  // being taken as a start bit
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    armed_d = armed_q | rxs;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxs) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_W) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_W) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_W) begin
          cnt_d = '0;
          if (rxs) begin
            byte_d  = shift_q;
            bv_d    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/debug_cmd_rx.sv
// Debug command receiver: decodes host bytes into CPU
// halt level and single-step pulse.
module debug_cmd_rx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       halt,
  output logic       step,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_error
);

  logic halt_q, halt_d;
  logic step_q, step_d;
  logic hit_h, hit_c, hit_s;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frame_error)
  );

  assign hit_h = byte_valid && (rx_byte == CMD_HALT);
  assign hit_c = byte_valid && (rx_byte == CMD_CONT);
  assign hit_s = byte_valid && (rx_byte == CMD_STEP);

  always_comb begin
    halt_d = halt_q;
    step_d = 1'b0;
    unique case (1'b1)
      hit_h:   halt_d = 1'b1;
      hit_c:   halt_d = 1'b0;
      hit_s:   step_d = halt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      step_q <= step_d;
    end
  end

  assign halt = halt_q;
  assign step = step_q;

endmodule
